// File: rtl/tlu_emulator.sv
// TLU-side trigger/busy handshake emulator: raises TRIGGER_OUT on request, waits for BUSY,
// shifts the trigger number LSB-first on DUT trigger-clock falling edges, then waits for BUSY low.
module tlu_emulator #(
    parameter int unsigned TRIG_BITS = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 CLK,
    input  logic                 RST_SYS,
    input  logic                 TRIG_REQ,
    input  logic                 BUSY_IN,
    input  logic                 TRIGGER_CLOCK_IN,
    output logic                 TRIGGER_OUT,
    output logic                 READY,
    output logic [TRIG_BITS-1:0] TRIG_NUM,
    output logic                 DONE,
    output logic                 TIMEOUT_ERR,
    output logic [15:0]          MISSED_CNT
);

    localparam int unsigned IdxW = (TRIG_BITS > 1) ? $clog2(TRIG_BITS) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(TRIG_BITS - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StTrig, StShift, StRelease} state_e;

    state_e               state_q, state_d;
    logic                 busy_s1_q, busy_s2_q;
    logic                 tck_s1_q, tck_s2_q, tck_last_q;
    logic                 tck_fall_q, tck_rise_q;
    logic [IdxW-1:0]      idx_q, idx_d, idx_nxt;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 trig_out_q, trig_out_d;
    logic [TRIG_BITS-1:0] trig_num_q, trig_num_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic [15:0]          missed_q, missed_d;
    logic                 ready;
    logic                 expired;

    // Not ready during the DONE/TIMEOUT_ERR cycle, so a coincident request counts as missed.
    assign ready   = (state_q == StIdle) && !done_q && !tmo_q;
    assign expired = (cnt_q == CntMax);
    assign idx_nxt = idx_q + 1'b1;

    always_ff @(posedge CLK or posedge RST_SYS) begin
        if (RST_SYS) begin
            state_q    <= StIdle;
            busy_s1_q  <= 1'b0;
            busy_s2_q  <= 1'b0;
            tck_s1_q   <= 1'b0;
            tck_s2_q   <= 1'b0;
            tck_last_q <= 1'b0;
            tck_fall_q <= 1'b0;
            tck_rise_q <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            trig_out_q <= 1'b0;
            trig_num_q <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_s1_q  <= BUSY_IN;
            busy_s2_q  <= busy_s1_q;
            tck_s1_q   <= TRIGGER_CLOCK_IN;
            tck_s2_q   <= tck_s1_q;
            tck_last_q <= tck_s2_q;
            tck_fall_q <= tck_last_q & ~tck_s2_q;
            tck_rise_q <= ~tck_last_q & tck_s2_q;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            trig_out_q <= trig_out_d;
            trig_num_q <= trig_num_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            missed_q   <= missed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        trig_out_d = trig_out_q;
        trig_num_d = trig_num_q;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        missed_d   = missed_q;

        if (TRIG_REQ && !ready && (missed_q != 16'hFFFF)) begin
            missed_d = missed_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (TRIG_REQ && ready) begin
                    state_d    = StTrig;
                    trig_out_d = 1'b1;
                end
            end
            StTrig: begin
                if (busy_s2_q) begin
                    state_d    = StShift;
                    trig_out_d = trig_num_q[0];
                    idx_d      = '0;
                    cnt_d      = '0;
                end else if (expired) begin
                    state_d    = StIdle;
                    trig_out_d = 1'b0;
                    tmo_d      = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (tck_fall_q) begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d    = StRelease;
                        trig_out_d = 1'b0;
                    end else begin
                        idx_d      = idx_nxt;
                        trig_out_d = trig_num_q[idx_nxt];
                    end
                end else if (tck_rise_q) begin
                    cnt_d = '0;
                end else if (expired) begin
                    state_d    = StIdle;
                    trig_out_d = 1'b0;
                    tmo_d      = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (!busy_s2_q) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    trig_num_d = trig_num_q + 1'b1;
                    cnt_d      = '0;
                end else if (expired) begin
                    state_d    = StIdle;
                    trig_out_d = 1'b0;
                    tmo_d      = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign TRIGGER_OUT = trig_out_q;
    assign READY       = ready;
    assign TRIG_NUM    = trig_num_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = tmo_q;
    assign MISSED_CNT  = missed_q;

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed bench for tlu_emulator: a DUT-side model answers each trigger and a scoreboard
// checks the serialized word against the trigger number expected at request time.
module tb_tlu_emulator;

    localparam int unsigned TB_BITS = 16;
    localparam int unsigned TB_TO   = 4096;

    logic        CLK = 1'b0;
    logic        RST_SYS = 1'b1;
    logic        TRIG_REQ = 1'b0;
    logic        BUSY_IN = 1'b0;
    logic        TRIGGER_CLOCK_IN = 1'b0;
    logic        TRIGGER_OUT;
    logic        READY;
    logic [15:0] TRIG_NUM;
    logic        DONE;
    logic        TIMEOUT_ERR;
    logic [15:0] MISSED_CNT;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_num = 16'h0000;
    logic [15:0] exp_missed = 16'h0000;
    logic [15:0] exp_q[$];

    tlu_emulator #(
        .TRIG_BITS(TB_BITS),
        .TIMEOUT  (TB_TO)
    ) dut (
        .CLK             (CLK),
        .RST_SYS         (RST_SYS),
        .TRIG_REQ        (TRIG_REQ),
        .BUSY_IN         (BUSY_IN),
        .TRIGGER_CLOCK_IN(TRIGGER_CLOCK_IN),
        .TRIGGER_OUT     (TRIGGER_OUT),
        .READY           (READY),
        .TRIG_NUM        (TRIG_NUM),
        .DONE            (DONE),
        .TIMEOUT_ERR     (TIMEOUT_ERR),
        .MISSED_CNT      (MISSED_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic force_num(input logic [15:0] v);
        force dut.trig_num_q = v;
        cyc(1);
        release dut.trig_num_q;
        cyc(1);
        exp_num = v;
        check("force_num", TRIG_NUM, v);
    endtask

    // Full handshake from the DUT side; n_miss requests are injected during SHIFT.
    task automatic handshake(input int n_miss, input bit req_on_done);
        logic [15:0] word;
        logic [15:0] exp_w;
        logic [15:0] nxt;
        int          sent;
        sent = 0;
        word = '0;
        exp_q.push_back(exp_num);
        TRIG_REQ = 1'b1;
        cyc(1);
        TRIG_REQ = 1'b0;
        check("trig_out_rise", TRIGGER_OUT, 1);
        check("ready_low", READY, 0);
        cyc(2);
        BUSY_IN = 1'b1;
        cyc(2);
        check("busy_sync_hold", TRIGGER_OUT, 1);
        cyc(1);
        check("bit0_load", TRIGGER_OUT, exp_num[0]);
        for (int i = 0; i < 16; i++) begin
            TRIGGER_CLOCK_IN = 1'b1;
            if (sent < n_miss && (i % 4) == 1) begin
                TRIG_REQ = 1'b1;
                cyc(1);
                TRIG_REQ = 1'b0;
                sent++;
                exp_missed = exp_missed + 16'd1;
                cyc(3);
            end else begin
                cyc(4);
            end
            word[i] = TRIGGER_OUT;
            TRIGGER_CLOCK_IN = 1'b0;
            cyc(4);
        end
        check("trig_out_end", TRIGGER_OUT, 0);
        check("num_held", TRIG_NUM, exp_num);
        exp_w = exp_q.pop_front();
        check("word", word, exp_w);
        BUSY_IN = 1'b0;
        cyc(2);
        check("done_early", DONE, 0);
        cyc(1);
        nxt = exp_num + 16'd1;
        check("done_pulse", DONE, 1);
        check("num_inc", TRIG_NUM, nxt);
        check("no_tmo", TIMEOUT_ERR, 0);
        check("ready_done_cyc", READY, 0);
        if (req_on_done) begin
            TRIG_REQ = 1'b1;
            exp_missed = exp_missed + 16'd1;
        end
        cyc(1);
        TRIG_REQ = 1'b0;
        check("done_single", DONE, 0);
        check("ready_after", READY, 1);
        check("missed_cnt", MISSED_CNT, exp_missed);
        exp_num = nxt;
        cyc(2);
    endtask

    initial begin
        cyc(2);
        RST_SYS = 1'b0;
        cyc(1);
        check("rst_trig_out", TRIGGER_OUT, 0);
        check("rst_ready", READY, 1);
        check("rst_num", TRIG_NUM, 0);
        check("rst_done", DONE, 0);
        check("rst_tmo", TIMEOUT_ERR, 0);
        check("rst_missed", MISSED_CNT, 0);

        handshake(0, 1'b0);

        force_num(16'hA5C3);
        handshake(0, 1'b0);

        // BUSY never rises: abort after TIMEOUT+1 cycles, number kept for retry.
        TRIG_REQ = 1'b1;
        cyc(1);
        TRIG_REQ = 1'b0;
        check("to_trig_out", TRIGGER_OUT, 1);
        cyc(TB_TO);
        check("to_not_yet", TIMEOUT_ERR, 0);
        check("to_out_held", TRIGGER_OUT, 1);
        cyc(1);
        check("to_pulse", TIMEOUT_ERR, 1);
        check("to_out_low", TRIGGER_OUT, 0);
        check("to_num_kept", TRIG_NUM, exp_num);
        check("to_no_done", DONE, 0);
        cyc(1);
        check("to_single", TIMEOUT_ERR, 0);
        check("to_ready", READY, 1);
        cyc(2);

        handshake(3, 1'b0);
        handshake(0, 1'b1);

        force_num(16'hFFFF);
        handshake(0, 1'b0);

        // Reset after the 7th falling edge of the trigger clock.
        TRIG_REQ = 1'b1;
        cyc(1);
        TRIG_REQ = 1'b0;
        cyc(2);
        BUSY_IN = 1'b1;
        cyc(4);
        for (int i = 0; i < 7; i++) begin
            TRIGGER_CLOCK_IN = 1'b1;
            cyc(4);
            TRIGGER_CLOCK_IN = 1'b0;
            cyc(4);
        end
        RST_SYS = 1'b1;
        BUSY_IN = 1'b0;
        #1;
        check("mid_rst_out", TRIGGER_OUT, 0);
        check("mid_rst_ready", READY, 1);
        check("mid_rst_num", TRIG_NUM, 0);
        check("mid_rst_done", DONE, 0);
        check("mid_rst_missed", MISSED_CNT, 0);
        cyc(2);
        RST_SYS = 1'b0;
        exp_num = 16'h0000;
        exp_missed = 16'h0000;
        cyc(3);
        check("post_rst_done", DONE, 0);
        handshake(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
